tune_ctrl: RTL
==============

// Module: tune_ctrl
// PURPOSE
// Retune/gain sequencer between the SPI register block and the NCO/CIC/AM-demod chain.
// Applies new NCO phase increments glitch-free, with audio muted until the CIC chain settles.
// Applies the audio gain slice and produces the 8-bit PWM level that feeds the PWM comparator.
// PARAMETERS
// PHASE_W      26          NCO phase increment width
// RESET_PHASE  26'h1312eb  phase_inc loaded at reset (936 kHz @ 50.25 MHz)
// SETTLE_TICKS 64          sample_tick pulses to wait after a retune before unmuting (>=1)
// MEAS_TICKS   256         sample_tick pulses per level measurement (power of 2; SCAN_EN only)
// PORTS
// clk            in   1        system clock (PLL output)
// RSTb           in   1        asynchronous active-low reset
// req_phase_inc  in   PHASE_W  requested phase increment (SPI register)
// req_gain       in   4        requested gain select (SPI register)
// sample_tick    in   1        1-cycle pulse, demod_in valid
// demod_in       in   16       AM demodulator output, unsigned
// nco_phase_inc  out  PHASE_W  phase increment driven to the NCO
// audio_level    out  8        PWM compare level
// mute           out  1        1 = audio_level forced to 0
// busy           out  1        1 while not in RUN
// BEHAVIOUR
// - Reset (async): nco_phase_inc=RESET_PHASE, audio_level=0, mute=1, busy=1, state=SETTLE, settle_cnt=0.
// - States: RUN, MUTE, APPLY, SETTLE (+MEASURE, STEP with SCAN_EN). All outputs registered.
// - RUN: mute=0, busy=0. If req_phase_inc != nco_phase_inc (sampled each cycle) -> MUTE.
// - MUTE: mute=1 one cycle -> APPLY. APPLY: nco_phase_inc<=req_phase_inc, settle_cnt<=0 -> SETTLE.
// - SETTLE: settle_cnt++ on each sample_tick; when count reaches SETTLE_TICKS -> RUN (mute drops
//   the cycle RUN is entered). Re-trigger: req_phase_inc differs from nco_phase_inc in SETTLE
//   -> APPLY (counter restarts). nco_phase_inc never changes outside APPLY/STEP.
// - Retune latency: request seen in RUN at cycle N -> nco_phase_inc updated at N+2.
// - Gain: g=min(req_gain[2:0],5), registered every cycle regardless of state (1-cycle latency).
//   Slice of demod_in: g=0 [15:8], 1 [14:7], 2 [13:6], 3 [12:5], 4 [11:4], 5 [10:3].
//   req_gain[3] ignored; values 6,7 clamp to 5.
// - audio_level: updated only on sample_tick (held between ticks); 0 whenever mute=1.
//   No saturation: bits above the slice are discarded (wrap).
// - sample_tick coinciding with a state change: counted by the state being left.
// CONFIGURATION
// SCAN_EN defined: adds ports scan_start in 1 (pulse), scan_step in PHASE_W, scan_end in PHASE_W,
//   scan_thresh in 16, scan_found out 1 (reset 0), scan_done out 1 (reset 0).
//   scan_start in RUN -> mute, clear scan_found/scan_done, then MEASURE: after SETTLE, sum demod_in
//   over MEAS_TICKS ticks; mean = sum >> log2(MEAS_TICKS). mean >= scan_thresh -> scan_found=1,
//   scan_done=1, RUN on that phase. Else STEP: nco_phase_inc += scan_step (mod 2^PHASE_W);
//   if the new value > scan_end -> restore pre-scan phase, scan_done=1, scan_found=0, RUN.
//   req_phase_inc changes ignored during scan; scan_start ignored outside RUN.
//   On exit, the tracked request is resynced to the current req_phase_inc so no spurious retune.
// SCAN_EN undefined: scan ports/states absent; no scan logic synthesised.
// TESTING
// 1 Reset, 64 ticks, req=RESET_PHASE -> mute=1 until 64th tick, then mute=0, busy=0, phase 26'h1312eb.
// 2 RUN, req->26'hbebd3 -> mute=1 next cycle, nco_phase_inc=26'hbebd3 at +2, unmute after 64 ticks.
// 3 Req 26'hbebd3 then 26'h213229 after 10 ticks -> final phase 26'h213229, mute held 64 ticks after 2nd.
// 4 demod_in=16'h1234, gain 0/2/7 -> audio_level 8'h12/8'h48/8'h46 (7 clamps to 5); 0 while muted.
// 5 Assert RSTb low mid-SETTLE -> outputs return to reset values immediately, same cycle.
// 6 SCAN_EN: start 26'h100000, step 26'h10000, end 26'h140000, demod 16'h0800 only at 26'h120000,
//   thresh 16'h0400 -> scan_found=1, phase 26'h120000; no hit -> phase restored, scan_found=0.

Source files
------------

// File: rtl/tune_ctrl.sv
// Retune/gain sequencer: glitch-free NCO retune with mute-until-settled, gain slice to PWM level.
// Optional frequency scan (MEASURE/STEP states, extra ports) is enabled by defining SCAN_EN.
module tune_ctrl #(
  parameter int                 PHASE_W      = 26,
  parameter logic [PHASE_W-1:0] RESET_PHASE  = 26'h1312eb,
  parameter int                 SETTLE_TICKS = 64,
  parameter int                 MEAS_TICKS   = 256
) (
  input  logic               clk,
  input  logic               RSTb,
  input  logic [PHASE_W-1:0] req_phase_inc,
  input  logic [3:0]         req_gain,
  input  logic               sample_tick,
  input  logic [15:0]        demod_in,
`ifdef SCAN_EN
  input  logic               scan_start,
  input  logic [PHASE_W-1:0] scan_step,
  input  logic [PHASE_W-1:0] scan_end,
  input  logic [15:0]        scan_thresh,
  output logic               scan_found,
  output logic               scan_done,
`endif
  output logic [PHASE_W-1:0] nco_phase_inc,
  output logic [7:0]         audio_level,
  output logic               mute,
  output logic               busy
);

  localparam int SCW = $clog2(SETTLE_TICKS + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_TICKS - 1);

  if (SETTLE_TICKS < 1) begin : g_bad_settle
    $error("SETTLE_TICKS must be at least 1");
  end
  if (MEAS_TICKS < 1 || (MEAS_TICKS & (MEAS_TICKS - 1)) != 0) begin : g_bad_meas
    $error("MEAS_TICKS must be a power of two");
  end

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_MUTE    = 3'd1,
    S_APPLY   = 3'd2,
    S_SETTLE  = 3'd3,
    S_MEASURE = 3'd4,
    S_STEP    = 3'd5
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [SCW-1:0]     settle_cnt;
  logic [2:0]         gain_q;
  logic [7:0]         slice;
  logic [PHASE_W-1:0] nco_nxt;
  logic [7:0]         level_nxt;
  logic               mute_nxt;
  logic [PHASE_W-1:0] track_phase;
  logic               retune;
  logic               unused_bits;

  // req_gain[3] and the low demod bits never reach the output slice.
  assign unused_bits = ^{req_gain[3], demod_in[2:0]};

`ifdef SCAN_EN
  localparam int MLOG = $clog2(MEAS_TICKS);
  localparam int MCW  = $clog2(MEAS_TICKS + 1);
  localparam int SUMW = 16 + MLOG;

  logic               scanning;
  logic [PHASE_W-1:0] scan_save;
  logic [MCW-1:0]     meas_cnt;
  logic [SUMW-1:0]    meas_sum;
  logic [SUMW-1:0]    sum_tot;
  logic [15:0]        mean;
  logic               meas_last;
  logic               hit;
  logic               scan_go;

  assign sum_tot   = meas_sum + SUMW'(demod_in);
  assign mean      = sum_tot[SUMW-1:MLOG];
  assign meas_last = (meas_cnt == MCW'(MEAS_TICKS - 1));
  assign hit       = (mean >= scan_thresh);
  assign scan_go   = (state == S_RUN) && scan_start;
`else
  assign track_phase = nco_phase_inc;
`endif

  assign retune = (req_phase_inc != track_phase);

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      state         <= S_SETTLE;
      settle_cnt    <= '0;
      gain_q        <= '0;
      nco_phase_inc <= RESET_PHASE;
      audio_level   <= '0;
      mute          <= 1'b1;
      busy          <= 1'b1;
    end else begin
      state         <= next_state;
      settle_cnt    <= (state == S_SETTLE) ? settle_cnt + SCW'(sample_tick) : '0;
      gain_q        <= (req_gain[2:0] > 3'd5) ? 3'd5 : req_gain[2:0];
      nco_phase_inc <= nco_nxt;
      audio_level   <= level_nxt;
      mute          <= mute_nxt;
      busy          <= mute_nxt;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RUN: begin
        if (retune) next_state = S_MUTE;
`ifdef SCAN_EN
        if (scan_start) next_state = S_MUTE;
`endif
      end
      S_MUTE: begin
        next_state = S_APPLY;
`ifdef SCAN_EN
        if (scanning) next_state = S_SETTLE;
`endif
      end
      S_APPLY: next_state = S_SETTLE;
      S_SETTLE: begin
        if (sample_tick && settle_cnt == SETTLE_LAST) next_state = S_RUN;
`ifdef SCAN_EN
        if (sample_tick && settle_cnt == SETTLE_LAST && scanning) next_state = S_MEASURE;
        if (retune && !scanning) next_state = S_APPLY;
`else
        if (retune) next_state = S_APPLY;
`endif
      end
`ifdef SCAN_EN
      S_MEASURE: if (sample_tick && meas_last) next_state = hit ? S_RUN : S_STEP;
      S_STEP:    next_state = (nco_phase_inc > scan_end) ? S_RUN : S_SETTLE;
`endif
      default: next_state = S_SETTLE;
    endcase
  end

  always_comb begin
    case (gain_q)
      3'd0:    slice = demod_in[15:8];
      3'd1:    slice = demod_in[14:7];
      3'd2:    slice = demod_in[13:6];
      3'd3:    slice = demod_in[12:5];
      3'd4:    slice = demod_in[11:4];
      default: slice = demod_in[10:3];
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they belong to.
  always_comb begin
    nco_nxt = nco_phase_inc;
    if (next_state == S_APPLY) nco_nxt = req_phase_inc;
`ifdef SCAN_EN
    if (next_state == S_STEP) nco_nxt = nco_phase_inc + scan_step;
    if (state == S_STEP && next_state == S_RUN) nco_nxt = scan_save;
`endif
    mute_nxt  = (next_state != S_RUN);
    level_nxt = audio_level;
    if (mute_nxt) level_nxt = '0;
    else if (sample_tick) level_nxt = slice;
  end

`ifdef SCAN_EN
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      scanning    <= 1'b0;
      scan_save   <= RESET_PHASE;
      track_phase <= RESET_PHASE;
      meas_cnt    <= '0;
      meas_sum    <= '0;
      scan_found  <= 1'b0;
      scan_done   <= 1'b0;
    end else begin
      if (scan_go) begin
        scanning   <= 1'b1;
        scan_save  <= nco_phase_inc;
        scan_found <= 1'b0;
        scan_done  <= 1'b0;
      end else if (scanning && next_state == S_RUN) begin
        // Resync so the request left untouched during the scan does not retune on exit.
        scanning    <= 1'b0;
        track_phase <= req_phase_inc;
        scan_found  <= (state == S_MEASURE);
        scan_done   <= 1'b1;
      end
      if (next_state == S_APPLY) track_phase <= req_phase_inc;
      if (state == S_MEASURE) begin
        if (sample_tick) begin
          meas_cnt <= meas_cnt + 1'b1;
          meas_sum <= sum_tot;
        end
      end else begin
        meas_cnt <= '0;
        meas_sum <= '0;
      end
    end
  end
`endif

endmodule
